// File: rtl/vfu_result_wb_arbiter_if.sv
// Result write-back bundle between the vector functional units, the
// write-back arbiter and the VRF bank write port.
//   master : FU / VRF side (drives FU requests + payloads and vrf_gnt_i)
//   slave  : arbiter side (drives FU grants, VRF request/payload, acks, busy)
// ALU and MFPU ports carry {req, id, addr, wdata, be} in and gnt out;
// the VRF port carries {req, addr, wdata, be, id, src} out and gnt in;
// wb_ack_valid_o/wb_ack_id_o report each retired word; busy_o flags
// outstanding work.
interface vfu_result_wb_arbiter_if #(
  parameter int unsigned VAddrWidth = 10,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned NrVInsn    = 8
);
  localparam int unsigned VidWidth = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;
  localparam int unsigned BeWidth  = DataWidth / 8;

  logic                  alu_result_req_i;
  logic [VidWidth-1:0]   alu_result_id_i;
  logic [VAddrWidth-1:0] alu_result_addr_i;
  logic [DataWidth-1:0]  alu_result_wdata_i;
  logic [BeWidth-1:0]    alu_result_be_i;
  logic                  alu_result_gnt_o;

  logic                  mfpu_result_req_i;
  logic [VidWidth-1:0]   mfpu_result_id_i;
  logic [VAddrWidth-1:0] mfpu_result_addr_i;
  logic [DataWidth-1:0]  mfpu_result_wdata_i;
  logic [BeWidth-1:0]    mfpu_result_be_i;
  logic                  mfpu_result_gnt_o;

  logic                  vrf_req_o;
  logic [VAddrWidth-1:0] vrf_addr_o;
  logic [DataWidth-1:0]  vrf_wdata_o;
  logic [BeWidth-1:0]    vrf_be_o;
  logic [VidWidth-1:0]   vrf_id_o;
  logic                  vrf_src_o;
  logic                  vrf_gnt_i;

  logic                  wb_ack_valid_o;
  logic [VidWidth-1:0]   wb_ack_id_o;
  logic                  busy_o;

  modport master (
    output alu_result_req_i, alu_result_id_i, alu_result_addr_i,
           alu_result_wdata_i, alu_result_be_i,
    input  alu_result_gnt_o,
    output mfpu_result_req_i, mfpu_result_id_i, mfpu_result_addr_i,
           mfpu_result_wdata_i, mfpu_result_be_i,
    input  mfpu_result_gnt_o,
    input  vrf_req_o, vrf_addr_o, vrf_wdata_o, vrf_be_o, vrf_id_o, vrf_src_o,
    output vrf_gnt_i,
    input  wb_ack_valid_o, wb_ack_id_o, busy_o
  );

  modport slave (
    input  alu_result_req_i, alu_result_id_i, alu_result_addr_i,
           alu_result_wdata_i, alu_result_be_i,
    output alu_result_gnt_o,
    input  mfpu_result_req_i, mfpu_result_id_i, mfpu_result_addr_i,
           mfpu_result_wdata_i, mfpu_result_be_i,
    output mfpu_result_gnt_o,
    output vrf_req_o, vrf_addr_o, vrf_wdata_o, vrf_be_o, vrf_id_o, vrf_src_o,
    input  vrf_gnt_i,
    output wb_ack_valid_o, wb_ack_id_o, busy_o
  );
endinterface

// File: rtl/vfu_result_wb_arbiter.sv
// Arbitrates ALU and MFPU result words onto a single VRF write port.
// Each source has its own FifoDepth-entry FIFO; a two-state output FSM
// (IDLE/REQ) presents the head of the round-robin selected FIFO and holds
// it stable until the VRF grants. Every VRF transfer is acknowledged one
// cycle later with the word's instruction id.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - slave side of vfu_result_wb_arbiter_if (FU, VRF, ack, busy)
module vfu_result_wb_arbiter #(
  parameter int unsigned VAddrWidth = 10,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned NrVInsn    = 8,
  parameter int unsigned FifoDepth  = 2
) (
  input logic                    clk_i,
  input logic                    rst_i,
  vfu_result_wb_arbiter_if.slave bus
);
  localparam int unsigned VidWidth   = (NrVInsn > 1) ? $clog2(NrVInsn) : 1;
  localparam int unsigned BeWidth    = DataWidth / 8;
  localparam int unsigned EntryWidth = VidWidth + VAddrWidth + DataWidth + BeWidth;
  localparam int unsigned PtrWidth   = $clog2(FifoDepth);
  localparam int unsigned CntWidth   = $clog2(FifoDepth + 1);
  localparam int unsigned NrSrc      = 2;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;
  typedef logic [EntryWidth-1:0] entry_t;

  entry_t              mem_q      [NrSrc][FifoDepth];
  logic [PtrWidth-1:0] wptr_q     [NrSrc];
  logic [PtrWidth-1:0] rptr_q     [NrSrc];
  logic [CntWidth-1:0] cnt_q      [NrSrc];
  logic [CntWidth-1:0] cnt_n      [NrSrc];
  logic                req        [NrSrc];
  logic                gnt        [NrSrc];
  logic                full       [NrSrc];
  logic                pop        [NrSrc];
  logic                nonempty_n [NrSrc];
  entry_t              wentry     [NrSrc];
  entry_t              head       [NrSrc];

  state_e              state_q, state_n;
  logic                src_q, src_n;
  logic                rr_q, rr_n;
  logic                pick;
  logic                any_n;
  logic                vrf_req;
  logic                xfer;
  entry_t              sel_entry;
  logic                ack_valid_q;
  logic [VidWidth-1:0] ack_id_q;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign req[0]    = bus.alu_result_req_i;
  assign req[1]    = bus.mfpu_result_req_i;
  assign wentry[0] = {bus.alu_result_id_i, bus.alu_result_addr_i,
                      bus.alu_result_wdata_i, bus.alu_result_be_i};
  assign wentry[1] = {bus.mfpu_result_id_i, bus.mfpu_result_addr_i,
                      bus.mfpu_result_wdata_i, bus.mfpu_result_be_i};

  assign vrf_req   = (state_q == REQ);
  assign xfer      = vrf_req & bus.vrf_gnt_i;
  assign sel_entry = src_q ? head[1] : head[0];

  // Grant depends only on registered occupancy, so a full FIFO refuses a
  // word even while it is popping in the same cycle.
  always_comb begin
    for (int unsigned s = 0; s < NrSrc; s++) begin
      full[s]       = (cnt_q[s] == CntWidth'(FifoDepth));
      gnt[s]        = req[s] & ~full[s] & ~rst_i;
      pop[s]        = xfer & (src_q == s[0]);
      head[s]       = mem_q[s][rptr_q[s]];
      cnt_n[s]      = cnt_q[s] + CntWidth'(gnt[s]) - CntWidth'(pop[s]);
      nonempty_n[s] = (cnt_n[s] != '0);
    end
  end

  // Arbitration looks at post-edge occupancy so a word pushed this cycle
  // is presented next cycle (1-cycle latency from an idle output).
  always_comb begin
    rr_n    = xfer ? ~src_q : rr_q;
    any_n   = nonempty_n[0] | nonempty_n[1];
    pick    = (nonempty_n[0] & nonempty_n[1]) ? rr_n : nonempty_n[1];
    state_n = state_q;
    src_n   = src_q;
    case (state_q)
      IDLE: begin
        if (any_n) begin
          state_n = REQ;
          src_n   = pick;
        end
      end
      REQ: begin
        if (bus.vrf_gnt_i) begin
          if (any_n) src_n = pick;
          else       state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      src_q       <= 1'b0;
      rr_q        <= 1'b0;
      ack_valid_q <= 1'b0;
      ack_id_q    <= '0;
      for (int unsigned s = 0; s < NrSrc; s++) begin
        cnt_q[s]  <= '0;
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
      end
    end else begin
      state_q     <= state_n;
      src_q       <= src_n;
      rr_q        <= rr_n;
      ack_valid_q <= xfer;
      if (xfer) ack_id_q <= sel_entry[EntryWidth-1 -: VidWidth];
      for (int unsigned s = 0; s < NrSrc; s++) begin
        cnt_q[s] <= cnt_n[s];
        if (gnt[s]) wptr_q[s] <= ptr_inc(wptr_q[s]);
        if (pop[s]) rptr_q[s] <= ptr_inc(rptr_q[s]);
      end
    end
  end

  // Storage needs no reset: occupancy counters gate every read.
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NrSrc; s++) begin
      if (gnt[s]) mem_q[s][wptr_q[s]] <= wentry[s];
    end
  end

  assign bus.alu_result_gnt_o  = gnt[0];
  assign bus.mfpu_result_gnt_o = gnt[1];
  assign bus.vrf_req_o         = vrf_req;
  assign bus.vrf_src_o         = vrf_req & src_q;
  assign {bus.vrf_id_o, bus.vrf_addr_o, bus.vrf_wdata_o, bus.vrf_be_o} =
      vrf_req ? sel_entry : '0;
  assign bus.wb_ack_valid_o    = ack_valid_q;
  assign bus.wb_ack_id_o       = ack_id_q;
  assign bus.busy_o            = (cnt_q[0] != '0) | (cnt_q[1] != '0) | ack_valid_q;
endmodule

// File: doc/vfu_result_wb_arbiter.md
VFU_RESULT_WB_ARBITER -- requirements
Module: vfu_result_wb_arbiter

Interface
REQ-001 SHALL have parameter VAddrWidth, default 10: VRF word address width.
REQ-002 SHALL have parameter DataWidth, default 64: result word width (elen); strobe width is DataWidth/8.
REQ-003 SHALL have parameter NrVInsn, default 8: vector instruction IDs; vid width = clog2(NrVInsn).
REQ-004 SHALL have parameter FifoDepth, default 2: entries per source FIFO, at least 2.
REQ-005 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, asynchronous and active-high.
REQ-007 SHALL have port alu_result_req_i  in  1  ALU write request.
REQ-008 SHALL have ports alu_result_id_i/addr_i/wdata_i/be_i  in  vid/VAddrWidth/DataWidth/DataWidth/8  ALU write payload.
REQ-009 SHALL have port alu_result_gnt_o  out  1  ALU write accepted this cycle.
REQ-010 SHALL have ports mfpu_result_req_i, mfpu_result_id_i/addr_i/wdata_i/be_i, mfpu_result_gnt_o  with the same widths and meanings for the MFPU.
REQ-011 SHALL have port vrf_req_o  out  1  write request to VRF bank.
REQ-012 SHALL have ports vrf_addr_o/wdata_o/be_o/id_o  out  VAddrWidth/DataWidth/DataWidth/8/vid  VRF write payload.
REQ-013 SHALL have port vrf_src_o  out  1  source of vrf_req_o (0 ALU, 1 MFPU).
REQ-014 SHALL have port vrf_gnt_i  in  1  VRF accepted the write this cycle.
REQ-015 SHALL have port wb_ack_valid_o  out  1  pulse: one result word retired.
REQ-016 SHALL have port wb_ack_id_o  out  vid  vid of the retired word.
REQ-017 SHALL have port busy_o  out  1  any FIFO non-empty or ack pending.

Function
REQ-018 An FU transfer SHALL occur when req & gnt are both high in a cycle; the FU holds req and payload until then.
REQ-019 x_result_gnt_o SHALL equal x_result_req_i & !fifo_x_full; a full FIFO SHALL NOT grant, even if it pops in the same cycle.
REQ-020 Each source SHALL have its own FIFO of FifoDepth entries {id,addr,wdata,be}; each source's order SHALL be preserved.
REQ-021 An accepted word SHALL reach vrf_req_o no earlier than the next cycle; with empty FIFOs and an idle output, latency SHALL be exactly 1 cycle.
REQ-022 Output FSM states: IDLE (vrf_req_o=0) and REQ (vrf_req_o=1).
- IDLE -> REQ: when any FIFO is non-empty; the round-robin pointer picks the source.
- REQ -> REQ: on vrf_gnt_i with a FIFO still non-empty; re-arbitrate.
- REQ -> IDLE: on vrf_gnt_i with both FIFOs empty after the pop.
REQ-023 In REQ without vrf_gnt_i, vrf_src_o and all vrf payload outputs SHALL stay stable; the source SHALL NOT switch.
REQ-024 Round-robin:
- The pointer resets to ALU.
- After a VRF transfer from source s, the pointer SHALL point to the other source.
- If only one FIFO is non-empty, that FIFO SHALL be chosen regardless of the pointer.
REQ-025 The head entry SHALL pop on vrf_req_o & vrf_gnt_i; a push and pop on the same FIFO in one cycle SHALL leave its occupancy unchanged.
REQ-026 wb_ack_valid_o SHALL pulse for exactly 1 cycle, the cycle after each VRF transfer, with wb_ack_id_o = that word's vid.
REQ-027 vrf_gnt_i while vrf_req_o=0 SHALL be ignored.
REQ-028 Occupancy counters SHALL span 0..FifoDepth and SHALL NOT wrap; read/write pointers SHALL wrap modulo FifoDepth.
REQ-029 busy_o SHALL be 0 only when both FIFOs are empty and wb_ack_valid_o=0.

Reset
REQ-030 While rst_i=1, asynchronously:
- both FIFOs SHALL empty;
- the FSM SHALL go to IDLE and the pointer to ALU;
- vrf_req_o, wb_ack_valid_o, busy_o, vrf_src_o, vrf_addr_o, vrf_wdata_o, vrf_be_o, vrf_id_o and wb_ack_id_o SHALL be 0.
REQ-031 gnt outputs SHALL be 0 during reset; reset mid-transfer SHALL drop in-flight words without emitting an ack.
REQ-032 After rst_i falls, the first grant SHALL be possible in the same cycle a request is presented.

Verification
REQ-033 ALU req id=3 addr=0x010 wdata=0xA5A5 be=0xFF, vrf_gnt_i=1 -> gnt same cycle; vrf_req_o next cycle with that payload and src=0; ack id=3 one cycle later.
REQ-034 ALU and MFPU each push 2 words simultaneously, vrf_gnt_i=1 -> VRF order ALU0, MFPU0, ALU1, MFPU1.
REQ-035 vrf_gnt_i=0 for 5 cycles, ALU pushes 3 words -> gnts on first 2 only; vrf payload stable all 5 cycles; third word granted the cycle after the first pop.
REQ-036 FIFO full, with a pop and a new req in the same cycle -> gnt=0 that cycle, gnt=1 next cycle; occupancy never exceeds 2.
REQ-037 rst_i pulse while vrf_req_o=1 with both FIFOs full -> all outputs 0, no ack; after release, ALU has priority.
REQ-038 Only MFPU active, 4 words with vrf_gnt_i toggling -> in-order delivery with src=1; each ack id matches the delivered word.
